// File: rtl/sram_resp.sv
// Word-organised memory responder for the single-outstanding req/rvalid protocol.
// Serves one read or byte-masked write at a time with a fixed response latency.
module sram_resp #(
   parameter logic [31:0] BASE_ADDR  = 32'h8000_0000,
   parameter int          DEPTH_LOG2 = 10,
   parameter int          LATENCY    = 1
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        req_i,
   input  logic        wen_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] wdata_i,
   input  logic [3:0]  wmask_i,
   output logic        ready_o,
   output logic        rvalid_o,
   output logic [31:0] rdata_o,
   output logic        wdone_o,
   output logic        err_o
);

   // state   | meaning
   // ST_IDLE | ready for a request; with LATENCY=1 responds on the accept edge
   // ST_BUSY | counting down cnt_q; responds when cnt_q reaches 1
   typedef enum logic {ST_IDLE, ST_BUSY} state_e;

   localparam int unsigned WORDS = 2 ** DEPTH_LOG2;
   localparam logic [32:0] SPAN  = 33'd4 << DEPTH_LOG2;

   logic [31:0] mem [WORDS];

   state_e                state_q, state_d;
   logic [3:0]            cnt_q, cnt_d;
   logic                  wen_q;
   logic [DEPTH_LOG2-1:0] idx_q;
   logic [31:0]           wdata_q;
   logic [3:0]            wmask_q;
   logic                  inr_q;

   logic                  rvalid_q, rvalid_d;
   logic                  wdone_q, wdone_d;
   logic                  err_q, err_d;
   logic [31:0]           rdata_q, rdata_d;

   logic [31:0]           off;
   logic                  in_range;
   logic [DEPTH_LOG2-1:0] idx;
   logic                  accept;

   logic                  resp_fire;
   logic                  r_wen;
   logic [DEPTH_LOG2-1:0] r_idx;
   logic [31:0]           r_wdata;
   logic [3:0]            r_wmask;
   logic                  r_inr;

   // Unsigned subtract: addresses below BASE_ADDR wrap high and fall out of range.
   assign off      = addr_i - BASE_ADDR;
   assign in_range = {1'b0, off} < SPAN;
   assign idx      = off[DEPTH_LOG2+1:2];
   assign ready_o  = (state_q == ST_IDLE);
   assign accept   = req_i && ready_o;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      resp_fire = 1'b0;
      r_wen     = wen_q;
      r_idx     = idx_q;
      r_wdata   = wdata_q;
      r_wmask   = wmask_q;
      r_inr     = inr_q;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               if (LATENCY == 1) begin
                  resp_fire = 1'b1;
                  r_wen     = wen_i;
                  r_idx     = idx;
                  r_wdata   = wdata_i;
                  r_wmask   = wmask_i;
                  r_inr     = in_range;
               end else begin
                  state_d = ST_BUSY;
                  cnt_d   = 4'(LATENCY - 1);
               end
            end
         end
         ST_BUSY: begin
            if (cnt_q == 4'd1) begin
               resp_fire = 1'b1;
               state_d   = ST_IDLE;
               cnt_d     = 4'd0;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      rvalid_d = resp_fire && !r_wen;
      wdone_d  = resp_fire && r_wen;
      err_d    = resp_fire && !r_inr;
      rdata_d  = rdata_q;
      if (resp_fire && !r_wen) begin
         rdata_d = r_inr ? mem[r_idx] : 32'd0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= ST_IDLE;
         cnt_q    <= 4'd0;
         wen_q    <= 1'b0;
         idx_q    <= '0;
         wdata_q  <= 32'd0;
         wmask_q  <= 4'd0;
         inr_q    <= 1'b0;
         rvalid_q <= 1'b0;
         wdone_q  <= 1'b0;
         err_q    <= 1'b0;
         rdata_q  <= 32'd0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         rvalid_q <= rvalid_d;
         wdone_q  <= wdone_d;
         err_q    <= err_d;
         rdata_q  <= rdata_d;
         if (accept) begin
            wen_q   <= wen_i;
            idx_q   <= idx;
            wdata_q <= wdata_i;
            wmask_q <= wmask_i;
            inr_q   <= in_range;
         end
      end
   end

   // Backing store is never reset; a reset mid-transaction leaves the FSM idle so nothing commits.
   always_ff @(posedge clk_i) begin
      if (resp_fire && r_wen && r_inr) begin
         for (int b = 0; b < 4; b++) begin
            if (r_wmask[b]) begin
               mem[r_idx][8*b +: 8] <= r_wdata[8*b +: 8];
            end
         end
      end
   end

   assign rvalid_o = rvalid_q;
   assign wdone_o  = wdone_q;
   assign err_o    = err_q;
   assign rdata_o  = rdata_q;

endmodule
